// File: rtl/uart_rx_scheduler.sv
// Scheduler behind the Hamming(7,4) UART receiver: oversample strobe, single-bit
// correction, nibble pairing with timeout, and a 4-entry byte FIFO with flags.
module uart_rx_scheduler #(
  parameter int CLK_DIV       = 16,
  parameter int TIMEOUT_TICKS = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  output logic       rx_ena,
  input  logic [6:0] rx_code,
  input  logic       rx_valid,
  input  logic [1:0] rx_state,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       err_ovf,
  output logic       err_to,
  output logic [7:0] corr_cnt,
  output logic       pair_state
);

  localparam int              DW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [7:0]      TO_LAST  = 8'(TIMEOUT_TICKS - 1);
  localparam int              DPOS [4] = '{2, 4, 5, 6};

  typedef enum logic {
    WAIT_LO = 1'b0,
    WAIT_HI = 1'b1
  } pair_t;

  // ---------------------------------------------------------------------------
  // Oversample tick divider
  // ---------------------------------------------------------------------------
  logic [DW-1:0] div_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg <= '0;
    end else if (!en || div_cnt_reg == DIV_LAST) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  assign rx_ena = en && (div_cnt_reg == DIV_LAST);

  // ---------------------------------------------------------------------------
  // Hamming(7,4) syndrome and data-bit correction
  // ---------------------------------------------------------------------------
  logic [2:0] syn;
  logic [3:0] nibble;

  assign syn[0] = rx_code[0] ^ rx_code[2] ^ rx_code[4] ^ rx_code[6];
  assign syn[1] = rx_code[1] ^ rx_code[2] ^ rx_code[5] ^ rx_code[6];
  assign syn[2] = rx_code[3] ^ rx_code[4] ^ rx_code[5] ^ rx_code[6];

  // A nonzero syndrome names the flipped position (1-based); parity-bit hits
  // need no data fix but still count as a correction.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_data_fix
      assign nibble[gi] = rx_code[DPOS[gi]] ^ (syn == 3'(DPOS[gi] + 1));
    end
  endgenerate

  logic valid_ok;
  logic corr_evt;
  logic to_tick;

  assign valid_ok = en && rx_valid;
  assign corr_evt = valid_ok && (syn != 3'd0);
  assign to_tick  = rx_ena && (rx_state == 2'b00);

  // ---------------------------------------------------------------------------
  // Pairing FSM
  // ---------------------------------------------------------------------------
  pair_t      state_reg, state_next;
  logic [3:0] lo_reg;
  logic [7:0] to_cnt_reg;
  logic       load_lo, push, to_clr, to_inc, to_expire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= WAIT_LO;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load_lo    = 1'b0;
    push       = 1'b0;
    to_clr     = 1'b0;
    to_inc     = 1'b0;
    to_expire  = 1'b0;
    if (!en) begin
      state_next = WAIT_LO;
      to_clr     = 1'b1;
    end else begin
      unique case (state_reg)
        WAIT_LO: begin
          if (valid_ok) begin
            load_lo    = 1'b1;
            to_clr     = 1'b1;
            state_next = WAIT_HI;
          end
        end
        WAIT_HI: begin
          // A codeword arriving on the expiry tick still completes the pair.
          if (valid_ok) begin
            push       = 1'b1;
            state_next = WAIT_LO;
          end else if (to_tick) begin
            if (to_cnt_reg == TO_LAST) begin
              to_expire  = 1'b1;
              to_clr     = 1'b1;
              state_next = WAIT_LO;
            end else begin
              to_inc = 1'b1;
            end
          end
        end
        default: state_next = WAIT_LO;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_reg <= '0;
    end else if (to_clr) begin
      to_cnt_reg <= '0;
    end else if (to_inc) begin
      to_cnt_reg <= to_cnt_reg + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_reg <= '0;
    end else if (load_lo) begin
      lo_reg <= nibble;
    end else if (!en || to_expire) begin
      lo_reg <= '0;
    end
  end

  assign pair_state = state_reg;

  // ---------------------------------------------------------------------------
  // 4-entry byte FIFO
  // ---------------------------------------------------------------------------
  logic [7:0] mem_reg [4];
  logic [1:0] wr_ptr_reg, rd_ptr_reg;
  logic [2:0] count_reg;
  logic       full, pop, wr_ok, ovf_evt;
  logic [7:0] push_byte;

  assign push_byte = {nibble, lo_reg};
  assign full      = (count_reg == 3'd4);
  assign pop       = (count_reg != 3'd0) && m_ready;
  assign wr_ok     = push && (!full || pop);
  assign ovf_evt   = push && full && !pop;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_mem
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mem_reg[gi] <= '0;
        end else if (wr_ok && wr_ptr_reg == 2'(gi)) begin
          mem_reg[gi] <= push_byte;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_ok) wr_ptr_reg <= wr_ptr_reg + 2'd1;
      if (pop)   rd_ptr_reg <= rd_ptr_reg + 2'd1;
      unique case ({wr_ok, pop})
        2'b10:   count_reg <= count_reg + 3'd1;
        2'b01:   count_reg <= count_reg - 3'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign m_data  = mem_reg[rd_ptr_reg];
  assign m_valid = (count_reg != 3'd0);

  // ---------------------------------------------------------------------------
  // Host-visible flags; a setting event beats a same-cycle clear
  // ---------------------------------------------------------------------------
  logic       err_ovf_reg, err_to_reg;
  logic [7:0] corr_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_ovf_reg  <= 1'b0;
      err_to_reg   <= 1'b0;
      corr_cnt_reg <= '0;
    end else begin
      if (ovf_evt)  err_ovf_reg <= 1'b1;
      else if (clr) err_ovf_reg <= 1'b0;

      if (to_expire) err_to_reg <= 1'b1;
      else if (clr)  err_to_reg <= 1'b0;

      if (corr_evt) begin
        if (clr)                        corr_cnt_reg <= 8'd1;
        else if (corr_cnt_reg != 8'hFF) corr_cnt_reg <= corr_cnt_reg + 8'd1;
      end else if (clr) begin
        corr_cnt_reg <= '0;
      end
    end
  end

  assign err_ovf  = err_ovf_reg;
  assign err_to   = err_to_reg;
  assign corr_cnt = corr_cnt_reg;

endmodule

// File: tb/tb_uart_rx_scheduler.sv
// Directed bench for uart_rx_scheduler: divider, correction, pairing, FIFO,
// timeout, enable and asynchronous reset behaviour.
module tb_uart_rx_scheduler;

  localparam int CLK_DIV       = 16;
  localparam int TIMEOUT_TICKS = 255;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic       rx_ena;
  logic [6:0] rx_code;
  logic       rx_valid;
  logic [1:0] rx_state;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       err_ovf;
  logic       err_to;
  logic [7:0] corr_cnt;
  logic       pair_state;

  int n_checks = 0;
  int n_pass   = 0;

  uart_rx_scheduler #(
    .CLK_DIV      (CLK_DIV),
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clr       (clr),
    .rx_ena    (rx_ena),
    .rx_code   (rx_code),
    .rx_valid  (rx_valid),
    .rx_state  (rx_state),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .err_ovf   (err_ovf),
    .err_to    (err_to),
    .corr_cnt  (corr_cnt),
    .pair_state(pair_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else begin
      n_pass++;
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Reference Hamming(7,4) encoder: c[0..6] = p1,p2,d1,p4,d2,d3,d4
  function automatic logic [6:0] enc(input logic [3:0] n);
    logic [6:0] c;
    c[2] = n[0];
    c[4] = n[1];
    c[5] = n[2];
    c[6] = n[3];
    c[0] = n[0] ^ n[1] ^ n[3];
    c[1] = n[0] ^ n[2] ^ n[3];
    c[3] = n[1] ^ n[2] ^ n[3];
    return c;
  endfunction

  // Present one codeword for a single clk; returns on the negedge after capture.
  task automatic send(input logic [6:0] c);
    @(negedge clk);
    rx_code  = c;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send(enc(b[3:0]));
    send(enc(b[7:4]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_hi, second_hi, hits, ticks;
    logic [6:0] cw;
    logic [7:0] exp_q [5];

    rst_n = 1'b0; en = 1'b0; clr = 1'b0; rx_code = '0; rx_valid = 1'b0;
    rx_state = 2'b00; m_ready = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_rx_ena", rx_ena, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_err_ovf", err_ovf, 0);
    check("rst_err_to", err_to, 0);
    check("rst_corr_cnt", corr_cnt, 0);
    check("rst_pair_state", pair_state, 0);
    rst_n = 1'b1;

    // Divider: rx_ena lands in the CLK_DIV-th enabled cycle, then every CLK_DIV
    @(negedge clk);
    en = 1'b1;
    first_hi = -1; second_hi = -1; hits = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (rx_ena) begin
        hits++;
        if (first_hi < 0) first_hi = cyc;
        else if (second_hi < 0) second_hi = cyc;
      end
    end
    check("div_first", first_hi, CLK_DIV - 1);
    check("div_period", second_hi - first_hi, CLK_DIV);
    check("div_width_hits", hits, 2);

    // Clean byte
    m_ready = 1'b1;
    send(7'h52);
    check("clean_pair_hi", pair_state, 1);
    check("clean_no_valid_yet", m_valid, 0);
    send(7'h2D);
    check("clean_m_valid", m_valid, 1);
    check("clean_m_data", m_data, 8'h5A);
    check("clean_corr", corr_cnt, 0);
    check("clean_pair_lo", pair_state, 0);

    // Single correction, then all 7 positions from a cleared count
    send(7'h56);
    send(7'h2D);
    check("corr_c2_data", m_data, 8'h5A);
    check("corr_c2_cnt", corr_cnt, 1);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    check("corr_clr", corr_cnt, 0);
    for (int p = 0; p < 7; p++) begin
      cw = 7'h52 ^ (7'd1 << p);
      send(cw);
      send(7'h2D);
      check($sformatf("corr_pos%0d_data", p), m_data, 8'h5A);
      check($sformatf("corr_pos%0d_cnt", p), corr_cnt, p + 1);
    end
    send(7'h52);
    send(7'h2D ^ 7'h40);
    check("corr_hi_data", m_data, 8'h5A);
    check("corr_hi_cnt", corr_cnt, 8);

    // clr coinciding with a correction: the correction counts
    @(negedge clk);
    rx_code = 7'h56; rx_valid = 1'b1; clr = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; clr = 1'b0;
    check("clr_vs_corr", corr_cnt, 1);
    send(7'h2D);
    check("clr_vs_corr_data", m_data, 8'h5A);
    @(negedge clk);
    check("drained", m_valid, 0);

    // Overflow: five bytes into a stalled FIFO
    m_ready = 1'b0;
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 4; i++) begin
      send_byte(exp_q[i]);
      check($sformatf("ovf_no_err_%0d", i), err_ovf, 0);
    end
    send_byte(exp_q[4]);
    check("ovf_err", err_ovf, 1);
    check("ovf_m_valid", m_valid, 1);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    check("ovf_clr", err_ovf, 0);
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf_order_%0d", i), m_data, exp_q[i]);
      @(negedge clk);
    end
    check("ovf_empty", m_valid, 0);

    // Full FIFO with simultaneous push and pop
    m_ready = 1'b0;
    exp_q = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
    for (int i = 0; i < 4; i++) send_byte(exp_q[i]);
    send(enc(4'h5));
    @(negedge clk);
    rx_code = enc(4'h6); rx_valid = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; m_ready = 1'b0;
    check("pp_no_ovf", err_ovf, 0);
    m_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check($sformatf("pp_order_%0d", i), m_data, exp_q[i]);
      @(negedge clk);
    end
    check("pp_empty", m_valid, 0);

    // Timeout suppressed while a frame is in progress
    send(enc(4'h3));
    rx_state = 2'b10;
    repeat ((TIMEOUT_TICKS + 2) * CLK_DIV) @(negedge clk);
    check("supp_err_to", err_to, 0);
    check("supp_pair", pair_state, 1);
    rx_state = 2'b00;
    send(enc(4'h9));
    check("supp_data", m_data, 8'h93);

    // Timeout expiry after TIMEOUT_TICKS ticks
    send(enc(4'h7));
    ticks = 0;
    for (int cyc = 0; cyc < (TIMEOUT_TICKS + 4) * CLK_DIV; cyc++) begin
      if (err_to) break;
      if (rx_ena) ticks++;
      @(negedge clk);
    end
    check("to_ticks", ticks, TIMEOUT_TICKS);
    check("to_err", err_to, 1);
    check("to_pair", pair_state, 0);
    check("to_no_byte", m_valid, 0);
    send_byte(8'hC9);
    check("to_next_data", m_data, 8'hC9);
    check("to_next_valid", m_valid, 1);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    check("to_clr", err_to, 0);

    // Enable drop in WAIT_HI
    send(enc(4'h4));
    check("en_pair_hi", pair_state, 1);
    @(negedge clk); en = 1'b0;
    @(negedge clk);
    check("en_pair_lo", pair_state, 0);
    hits = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (rx_ena) hits++;
    end
    check("en_no_ticks", hits, 0);
    check("en_err_to", err_to, 0);
    send(enc(4'h4));
    check("en_ignore_valid", pair_state, 0);
    en = 1'b1;

    // Asynchronous reset with two bytes queued and a low nibble held
    m_ready = 1'b0;
    send_byte(8'h12);
    send(enc(4'h4) ^ 7'h01);
    send(enc(4'h3));
    send(enc(4'h8));
    check("ar_pre_pair", pair_state, 1);
    check("ar_pre_valid", m_valid, 1);
    check("ar_pre_corr", corr_cnt, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_m_valid", m_valid, 0);
    check("ar_m_data", m_data, 0);
    check("ar_pair", pair_state, 0);
    check("ar_corr", corr_cnt, 0);
    check("ar_rx_ena", rx_ena, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("ar_post_valid", m_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
